// File: rtl/cndm_micro_msi_gen.sv
// MSI interrupt generator: coalesces vector requests into a pending bitmap and
// issues them one at a time on the PCIe hard-block MSI interface, with
// round-robin arbitration, vector folding, timeout and retry back-off.
module cndm_micro_msi_gen #(
  parameter int IRQ_CNT     = 32,
  parameter int IRQ_IDX_W   = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1,
  parameter int TIMEOUT     = 1024,
  parameter int RETRY_DELAY = 64
) (
  input  logic                 pcie_clk,
  input  logic                 pcie_rst,

  input  logic [IRQ_IDX_W-1:0] s_irq_index,
  input  logic                 s_irq_valid,
  output logic                 s_irq_ready,

  input  logic [3:0]           cfg_interrupt_msi_enable,
  input  logic [11:0]          cfg_interrupt_msi_mmenable,
  output logic [31:0]          cfg_interrupt_msi_int,
  input  logic                 cfg_interrupt_msi_sent,
  input  logic                 cfg_interrupt_msi_fail,
  output logic [1:0]           cfg_interrupt_msi_select,
  output logic [31:0]          cfg_interrupt_msi_pending_status,
  output logic                 cfg_interrupt_msi_pending_status_data_enable,
  output logic [1:0]           cfg_interrupt_msi_pending_status_function_num,
  output logic [2:0]           cfg_interrupt_msi_attr,
  output logic                 cfg_interrupt_msi_tph_present,
  output logic [1:0]           cfg_interrupt_msi_tph_type,
  output logic [7:0]           cfg_interrupt_msi_tph_st_tag,
  output logic [7:0]           cfg_interrupt_msi_function_number,

  output logic [15:0]          stat_fail_cnt
);

  localparam int TMR_MAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;

  state_t               state_q, state_d;
  logic [IRQ_CNT-1:0]   pend_q, pend_d;
  logic [IRQ_IDX_W-1:0] cur_q, cur_d, last_q, last_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [15:0]          fail_cnt_q, fail_cnt_d;
  logic [31:0]          msi_int_q, msi_int_d;

  logic                 pick_vld;
  logic [IRQ_IDX_W-1:0] pick_idx;
  logic [2:0]           mm_log2;
  logic [4:0]           fold_mask, fold_idx;
  logic                 req_ok;
  logic                 unused_cfg;

  assign s_irq_ready = !pcie_rst;
  assign req_ok      = s_irq_valid && s_irq_ready && (int'(s_irq_index) < IRQ_CNT);

  // Host may allocate fewer vectors than we use; fold onto the allocated range.
  assign mm_log2   = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
  assign fold_mask = 5'((6'd1 << mm_log2) - 6'd1);
  assign fold_idx  = 5'(cur_q) & fold_mask;

  // Only function 0 is used; upper config bits are intentionally ignored.
  assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  // Round-robin pick: first pending vector scanning upward from last+1.
  always_comb begin : p_pick
    logic [IRQ_IDX_W-1:0] j;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = '0;
    for (int i = 0; i < IRQ_CNT; i++) begin
      j = IRQ_IDX_W'((int'(last_q) + 1 + i) % IRQ_CNT);
      if (!pick_vld && pend_q[j]) begin
        pick_vld = 1'b1;
        pick_idx = j;
      end
    end
  end

  // Next-state / datapath: arbitration, issue, sent/fail handling, back-off.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cur_d      = cur_q;
    last_d     = last_q;
    tmr_d      = tmr_q;
    fail_cnt_d = fail_cnt_q;
    msi_int_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (cfg_interrupt_msi_enable[0] && pick_vld) begin
          pend_d[pick_idx] = 1'b0;
          cur_d            = pick_idx;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        msi_int_d = 32'd1 << fold_idx;
        last_d    = cur_q;
        tmr_d     = TMR_W'(TIMEOUT - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        // sent takes priority over a simultaneous fail
        if (cfg_interrupt_msi_sent) begin
          state_d = IDLE;
        end else if (cfg_interrupt_msi_fail || tmr_q == '0) begin
          pend_d[cur_q] = 1'b1;
          if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
          tmr_d   = TMR_W'(RETRY_DELAY - 1);
          state_d = BACKOFF;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      BACKOFF: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // New requests land after the pick clear so a same-cycle repeat survives.
    if (req_ok) pend_d[s_irq_index] = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      cur_q      <= '0;
      last_q     <= IRQ_IDX_W'(IRQ_CNT - 1);
      tmr_q      <= '0;
      fail_cnt_q <= '0;
      msi_int_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      tmr_q      <= tmr_d;
      fail_cnt_q <= fail_cnt_d;
      msi_int_q  <= msi_int_d;
    end
  end

  assign cfg_interrupt_msi_int = msi_int_q;
  assign stat_fail_cnt         = fail_cnt_q;

  assign cfg_interrupt_msi_select                      = '0;
  assign cfg_interrupt_msi_pending_status              = '0;
  assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
  assign cfg_interrupt_msi_pending_status_function_num = '0;
  assign cfg_interrupt_msi_attr                        = '0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = '0;
  assign cfg_interrupt_msi_tph_st_tag                  = '0;
  assign cfg_interrupt_msi_function_number             = '0;

endmodule

// File: tb/tb_cndm_micro_msi_gen.sv
// Bench for cndm_micro_msi_gen: directed scenarios followed by randomized
// rounds checked against a pending-set / round-robin reference model.
module tb_cndm_micro_msi_gen;
  localparam int IRQ_CNT = 32;
  localparam int TIMEOUT = 1024;
  localparam int RD      = 64;

  logic        pcie_clk = 1'b0;
  logic        pcie_rst = 1'b1;
  logic [4:0]  s_irq_index = '0;
  logic        s_irq_valid = 1'b0;
  logic        s_irq_ready;
  logic [3:0]  en = '0;
  logic [11:0] mm = 12'd5;
  logic [31:0] msi_int;
  logic        sent = 1'b0, fail = 1'b0;
  logic [1:0]  t_sel, t_psfn, t_tpht;
  logic [31:0] t_ps;
  logic        t_psde, t_tphp;
  logic [2:0]  t_attr;
  logic [7:0]  t_tag, t_fn;
  logic [15:0] stat;

  int n_cmp = 0, n_bad = 0;

  // reference model state
  bit [31:0] m_pend;
  int        m_last, m_fail, m_mm;

  cndm_micro_msi_gen #(.IRQ_CNT(IRQ_CNT), .TIMEOUT(TIMEOUT), .RETRY_DELAY(RD)) dut (
    .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
    .s_irq_index(s_irq_index), .s_irq_valid(s_irq_valid), .s_irq_ready(s_irq_ready),
    .cfg_interrupt_msi_enable(en), .cfg_interrupt_msi_mmenable(mm),
    .cfg_interrupt_msi_int(msi_int),
    .cfg_interrupt_msi_sent(sent), .cfg_interrupt_msi_fail(fail),
    .cfg_interrupt_msi_select(t_sel),
    .cfg_interrupt_msi_pending_status(t_ps),
    .cfg_interrupt_msi_pending_status_data_enable(t_psde),
    .cfg_interrupt_msi_pending_status_function_num(t_psfn),
    .cfg_interrupt_msi_attr(t_attr),
    .cfg_interrupt_msi_tph_present(t_tphp),
    .cfg_interrupt_msi_tph_type(t_tpht),
    .cfg_interrupt_msi_tph_st_tag(t_tag),
    .cfg_interrupt_msi_function_number(t_fn),
    .stat_fail_cnt(stat)
  );

  always #5 pcie_clk = ~pcie_clk;

  function automatic logic [31:0] onehot(input int idx, input int mmv);
    int n;
    n = 1 << ((mmv > 5) ? 5 : mmv);
    return 32'd1 << (idx % n);
  endfunction

  function automatic int rr_pick(input bit [31:0] pend, input int last);
    for (int i = 1; i <= IRQ_CNT; i++)
      if (pend[(last + i) % IRQ_CNT]) return (last + i) % IRQ_CNT;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pcie_clk); #1;
  endtask

  task automatic req(input int idx);
    s_irq_index = 5'(idx);
    s_irq_valid = 1'b1;
    step();
    s_irq_valid = 1'b0;
  endtask

  task automatic resp(input logic s, input logic f);
    sent = s; fail = f;
    step();
    sent = 1'b0; fail = 1'b0;
  endtask

  task automatic wait_pulse(input int maxc, output bit got, output logic [31:0] v, output int dly);
    got = 1'b0; v = '0; dly = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge pcie_clk);
      if (msi_int !== 32'd0) begin
        got = 1'b1; v = msi_int; dly = i;
        break;
      end
    end
  endtask

  task automatic expect_pulse(input string tag, input int idx, input int maxc, output int dly);
    bit g;
    logic [31:0] v;
    wait_pulse(maxc, g, v, dly);
    chk({tag, "_seen"}, 32'(g), 32'd1);
    chk(tag, v, onehot(idx, m_mm));
    m_last = idx;
  endtask

  task automatic no_pulse(input string tag, input int n);
    bit g;
    logic [31:0] v;
    int d;
    wait_pulse(n, g, v, d);
    chk(tag, v, 32'd0);
  endtask

  task automatic chk_tied(input string tag);
    chk(tag, 32'(|{t_sel, t_psfn, t_ps, t_psde, t_tphp, t_attr, t_tpht, t_tag, t_fn}), 32'd0);
  endtask

  initial begin
    int d, exp_i, act, n, idx, guard;

    // reset state
    pcie_rst = 1'b1;
    repeat (3) step();
    @(negedge pcie_clk);
    chk("rst_ready", 32'(s_irq_ready), 32'd0);
    chk("rst_int", msi_int, 32'd0);
    chk("rst_stat", 32'(stat), 32'd0);
    chk_tied("rst_tied");
    step();
    pcie_rst = 1'b0;
    @(negedge pcie_clk);
    chk("ready", 32'(s_irq_ready), 32'd1);
    m_pend = '0; m_last = IRQ_CNT - 1; m_fail = 0; m_mm = 5;

    // disabled MSI: requests stay pending, then drain in order once enabled
    en = 4'b0000;
    req(0);
    req(9);
    no_pulse("dis_hold", 30);
    en = 4'b0001;
    expect_pulse("dis_p0", 0, 20, d);
    resp(1'b1, 1'b0);
    expect_pulse("dis_p9", 9, 20, d);
    resp(1'b1, 1'b0);
    no_pulse("dis_none", 20);

    // single request: pulse lands two cycles after acceptance, one cycle wide
    req(3);
    expect_pulse("single", 3, 20, d);
    chk("single_lat", 32'(d), 32'd3);
    resp(1'b1, 1'b0);
    @(negedge pcie_clk);
    chk("single_width", msi_int, 32'd0);
    no_pulse("single_none", 20);

    // folding onto 4 allocated vectors
    mm = 12'd2; m_mm = 2;
    req(13);
    expect_pulse("fold", 13, 20, d);
    chk("fold_val", onehot(13, 2), 32'h2);
    resp(1'b1, 1'b0);
    mm = 12'd5; m_mm = 5;
    no_pulse("fold_none", 10);

    // fail then timeout, each followed by a retry of the same vector
    req(7);
    expect_pulse("fail_p1", 7, 20, d);
    resp(1'b0, 1'b1);
    expect_pulse("fail_p2", 7, RD + 40, d);
    chk("retry_gap", 32'(d >= RD + 3), 32'd1);
    chk("fail_cnt1", 32'(stat), 32'd1);
    expect_pulse("tmo_p3", 7, TIMEOUT + RD + 40, d);
    chk("tmo_gap", 32'(d >= TIMEOUT + RD + 2), 32'd1);
    chk("fail_cnt2", 32'(stat), 32'd2);
    resp(1'b1, 1'b0);
    no_pulse("tmo_none", 20);

    // reset while waiting with the same vector re-requested
    req(4);
    expect_pulse("rst_p", 4, 20, d);
    repeat (3) step();
    req(4);
    pcie_rst = 1'b1;
    step();
    @(negedge pcie_clk);
    chk("mrst_int", msi_int, 32'd0);
    chk("mrst_ready", 32'(s_irq_ready), 32'd0);
    step();
    pcie_rst = 1'b0;
    @(negedge pcie_clk);
    chk("mrst_stat", 32'(stat), 32'd0);
    chk("mrst_int2", msi_int, 32'd0);
    chk_tied("mrst_tied");
    no_pulse("mrst_none", TIMEOUT + RD + 20);
    m_pend = '0; m_last = IRQ_CNT - 1; m_fail = 0;

    // coalesce and round-robin from a fresh scan position
    en = 4'b0000;
    req(5); req(5); req(2); req(31);
    no_pulse("coal_hold", 10);
    en = 4'b0001;
    expect_pulse("coal_p2", 2, 20, d);
    resp(1'b1, 1'b0);
    expect_pulse("coal_p5", 5, 20, d);
    resp(1'b1, 1'b1);
    expect_pulse("coal_p31", 31, 20, d);
    resp(1'b1, 1'b0);
    no_pulse("coal_none", 30);
    chk("coal_stat", 32'(stat), 32'd0);

    // randomized rounds against the reference model
    for (int r = 0; r < 12; r++) begin
      m_mm = int'($urandom_range(0, 7));
      mm   = {9'($urandom), 3'(m_mm)};
      en   = {3'($urandom), 1'b0};
      n    = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        idx = int'($urandom_range(0, IRQ_CNT - 1));
        m_pend[idx] = 1'b1;
        req(idx);
      end
      en = {3'($urandom), 1'b1};
      guard = 0;
      while (m_pend != 0 && guard < 40) begin
        exp_i = rr_pick(m_pend, m_last);
        m_pend[exp_i] = 1'b0;
        expect_pulse("rnd", exp_i, RD + 40, d);
        act = (guard > 20) ? 2 : int'($urandom_range(0, 3));
        if (act == 0) begin
          resp(1'b0, 1'b1);
          m_pend[exp_i] = 1'b1;
          m_fail++;
        end else if (act == 1) begin
          resp(1'b1, 1'b1);
        end else begin
          resp(1'b1, 1'b0);
        end
        guard++;
      end
      no_pulse("rnd_none", RD + 10);
      chk("rnd_stat", 32'(stat), 32'(m_fail));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cndm_micro_msi_gen.md
# cndm_micro_msi_gen

MSI interrupt generator for the cndm micro PCIe datapath. Accepts interrupt-vector requests from the NIC core (event/completion queues), coalesces them in a pending bitmap, and drives the UltraScale PCIe hard-block MSI interface (`cfg_interrupt_msi_*`) one vector at a time. It handles sent/fail handshakes, retry with back-off, and the host-programmed vector count. It sits between the queue logic and the PCIe core configuration ports in `pcie_clk`.

## Interface
Parameters:
- `IRQ_CNT`, 32: number of request vectors, 1..32.
- `IRQ_IDX_W`, `$clog2(IRQ_CNT)` (min 1): index width.
- `TIMEOUT`, 1024: cycles to wait for sent/fail before treating the request as failed.
- `RETRY_DELAY`, 64: back-off cycles after a fail, before re-arbitration.

Ports:
- `pcie_clk` in 1: sole clock.
- `pcie_rst` in 1: reset, synchronous, active-high.
- `s_irq_index` in `IRQ_IDX_W`: requested vector.
- `s_irq_valid` in 1: request valid.
- `s_irq_ready` out 1: request ready.
- `cfg_interrupt_msi_enable` in 4: bit 0 = MSI enabled for function 0.
- `cfg_interrupt_msi_mmenable` in 12: bits [2:0] = log2 of allocated vectors for function 0.
- `cfg_interrupt_msi_int` out 32: one-hot request pulse.
- `cfg_interrupt_msi_sent` in 1: core delivered the MSI.
- `cfg_interrupt_msi_fail` in 1: core rejected the MSI.
- `cfg_interrupt_msi_select`, `_pending_status_function_num` out 2: tied 0.
- `cfg_interrupt_msi_pending_status` out 32: tied 0.
- `cfg_interrupt_msi_pending_status_data_enable`, `_tph_present` out 1: tied 0.
- `cfg_interrupt_msi_attr` out 3, `_tph_type` out 2, `_tph_st_tag` out 8, `_function_number` out 8: tied 0.
- `stat_fail_cnt` out 16: saturating count of fails plus timeouts.

## Operation
- Request acceptance:
  - `s_irq_ready` is 1 whenever not in reset.
  - An accepted request with index ≥ `IRQ_CNT` is dropped.
  - Otherwise it sets `pending[idx]`.
  - A request for an already-pending vector coalesces into it; there is no counter.
- Vector folding:
  - `n_vec = 1 << min(mmenable[2:0], 5)`.
  - The issued MSI bit is `idx & (n_vec-1)`.
  - Folding applies only at issue time; `pending` keeps the original index.
- FSM states: IDLE, ISSUE, WAIT, BACKOFF.
  - **IDLE:** if `msi_enable[0]` and `pending != 0`, pick a vector round-robin: the first set bit searching upward from `last+1` modulo `IRQ_CNT`. Clear its pending bit, record it as `cur`, and go to ISSUE. If MSI is disabled, bits stay pending indefinitely.
  - **ISSUE:** `cfg_interrupt_msi_int` = one-hot of the folded `cur` for exactly this cycle. Set `last = cur`, load the timer with `TIMEOUT-1`, and go to WAIT.
  - **WAIT:**
    - `sent` → IDLE.
    - `fail`, or timer = 0 → re-set `pending[cur]`, increment `stat_fail_cnt` (saturating at 0xFFFF), load the timer with `RETRY_DELAY-1`, and go to BACKOFF.
    - Otherwise decrement the timer.
    - If `sent` and `fail` occur together, `sent` wins.
  - **BACKOFF:** decrement the timer; at 0 go to IDLE.
- MSI disable while in WAIT or BACKOFF: the FSM completes normally. If the vector is still pending it stays pending until MSI is re-enabled.
- A new request for `cur` during WAIT re-sets `pending[cur]`, which produces a second MSI after the current one completes.

## Timing
- Reset values:
  - `s_irq_ready` = 0 during reset.
  - `cfg_interrupt_msi_int` = 0.
  - `stat_fail_cnt` = 0.
  - `pending` = 0, `last` = `IRQ_CNT-1` (so the first scan starts at vector 0), FSM = IDLE.
  - All tied outputs are constant 0.
- Reset mid-operation drops all pending and in-flight state. No `msi_int` pulse is emitted in the cycle after reset is asserted.
- Latency, idle and enabled: request accepted at edge k → IDLE arbitrates at edge k+1 → `msi_int` is high for the single cycle after edge k+2.
- Issue spacing:
  - Minimum spacing between successive `msi_int` pulses is 3 cycles, when `sent` is returned the cycle after the pulse.
  - At most one MSI is outstanding at a time.
- `msi_int` is registered; all FSM decisions use the registered `sent`/`fail` sampled at the clock edge.
- Retry: a fail sampled at edge f → the next pulse for the same vector comes no earlier than edge f + `RETRY_DELAY` + 2.

## Test plan
- **Single request:** enable=1, mmenable=5, request idx 3 → `msi_int` = 0x00000008 for one cycle, 2 cycles after acceptance; `sent` → IDLE, no further pulses.
- **Coalesce and round-robin:**
  - Setup: requests idx 5, 5, 2, 31 in consecutive cycles; `sent` returned immediately each time.
  - Required: pulses in order 2, 5, 31, with exactly three pulses.
- **Folding:** mmenable=2 (4 vectors), request idx 13 → `msi_int` = 0x00000002.
- **Fail/timeout:**
  - Fail: drive `fail` for the first attempt of idx 7 → re-issue of idx 7 after ≥ `RETRY_DELAY` + 2 cycles, and `stat_fail_cnt` = 1.
  - Timeout: no response for `TIMEOUT` cycles → `stat_fail_cnt` = 2 and another re-issue.
- **Disabled MSI:** enable=0, requests idx 0 and 9 → no pulses. Set enable=1 → pulses 0 then 9.
- **Reset mid-WAIT:** assert `pcie_rst` while in WAIT with idx 4 pending → after release, all outputs are 0 and no pulse appears without a new request.
